// File: rtl/dsp_pkg.sv
// Shared constants for the DSP multiply-accumulate BEL: ConfigBits layout, accumulate
// modes and the pipeline latency helper.
package dsp_pkg;

  localparam int unsigned CFG_SIGNED     = 0;
  localparam int unsigned CFG_AREG       = 1;
  localparam int unsigned CFG_BREG       = 2;
  localparam int unsigned CFG_MODE       = 3;
  localparam int unsigned CFG_OVF_STICKY = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  // A/B-to-Q latency; one input register on either side delays both operands.
  function automatic int unsigned pipe_latency(input logic areg, input logic breg);
    return (areg || breg) ? 3 : 2;
  endfunction

endpackage

// File: rtl/dsp_mac_bel_if.sv
// Operand/result bundle of the DSP MAC BEL as routed through the switch matrix.
interface dsp_mac_bel_if #(
  parameter int unsigned A_WIDTH   = 8,
  parameter int unsigned B_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH = 20
);
  logic [A_WIDTH-1:0]   A;
  logic [B_WIDTH-1:0]   B;
  logic [ACC_WIDTH-1:0] C;
  logic                 ce;
  logic                 clr;
  logic                 in_valid;
  logic [ACC_WIDTH-1:0] Q;
  logic                 out_valid;
  logic                 ovf;

  modport master (
    output A, B, C, ce, clr, in_valid,
    input  Q, out_valid, ovf
  );

  modport slave (
    input  A, B, C, ce, clr, in_valid,
    output Q, out_valid, ovf
  );
endinterface

// File: rtl/dsp_mult.sv
// Combinational signed/unsigned multiplier, kept separate so a hardened macro can replace it.
module dsp_mult #(
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned B_WIDTH = 8
) (
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic                       is_signed,
  output logic [A_WIDTH+B_WIDTH-1:0] p
);
  localparam int unsigned PW = A_WIDTH + B_WIDTH;

  logic signed [PW-1:0] p_signed;
  logic        [PW-1:0] p_unsigned;

  // Operands are extended to full width explicitly so each product is exact.
  assign p_signed   = $signed({{B_WIDTH{a[A_WIDTH-1]}}, a}) *
                      $signed({{A_WIDTH{b[B_WIDTH-1]}}, b});
  assign p_unsigned = {{B_WIDTH{1'b0}}, a} * {{A_WIDTH{1'b0}}, b};
  assign p          = is_signed ? p_signed : p_unsigned;
endmodule

// File: rtl/dsp_mac_bel.sv
// Parametrised multiply-accumulate BEL with optional input registers and two accumulate modes.
// Define DSP_MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module dsp_mac_bel
  import dsp_pkg::*;
#(
  parameter int unsigned A_WIDTH      = 8,
  parameter int unsigned B_WIDTH      = 8,
  parameter int unsigned ACC_WIDTH    = 20,
  parameter int unsigned NoConfigBits = 5
) (
  input  logic                    UserCLK,
  input  logic                    resetn,
  input  logic [NoConfigBits-1:0] ConfigBits,
  dsp_mac_bel_if.slave            bus
);
  localparam int unsigned PW = A_WIDTH + B_WIDTH;

  if (ACC_WIDTH < PW) begin : g_width_check
    $error("dsp_mac_bel: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
  end

  logic cfg_signed, cfg_mode, cfg_sticky, any_reg;
  assign cfg_signed = ConfigBits[CFG_SIGNED];
  assign cfg_mode   = ConfigBits[CFG_MODE];
  assign cfg_sticky = ConfigBits[CFG_OVF_STICKY];
  assign any_reg    = pipe_latency(ConfigBits[CFG_AREG], ConfigBits[CFG_BREG]) == 3;

  // S0: both operands and tags are captured so a bypassed side stays aligned with a
  // registered one.
  logic [A_WIDTH-1:0] a_q;
  logic [B_WIDTH-1:0] b_q;
  logic               v0_q, clr0_q;
  logic [A_WIDTH-1:0] a_eff;
  logic [B_WIDTH-1:0] b_eff;
  logic               v_eff, clr_eff;
  logic [PW-1:0]      prod;

  assign a_eff   = any_reg ? a_q    : bus.A;
  assign b_eff   = any_reg ? b_q    : bus.B;
  assign v_eff   = any_reg ? v0_q   : bus.in_valid;
  assign clr_eff = any_reg ? clr0_q : bus.clr;

  dsp_mult #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH)
  ) u_mult (
    .a         (a_eff),
    .b         (b_eff),
    .is_signed (cfg_signed),
    .p         (prod)
  );

  logic [PW-1:0]        p_q;
  logic                 v1_q, clr1_q, v2_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  // S2 datapath: clr travels with its operands and replaces the addend by zero.
  logic signed [PW:0]   p_sx;
  logic [ACC_WIDTH-1:0] p_ext, addend;
  logic [ACC_WIDTH:0]   sum;
  logic                 upd_ovf;

  always_comb begin
    p_sx   = {cfg_signed & p_q[PW-1], p_q};
    p_ext  = ACC_WIDTH'(p_sx);
    addend = '0;
    if (!clr1_q) begin
      addend = (cfg_mode == MODE_ADD) ? bus.C : acc_q;
    end
    sum = {1'b0, p_ext} + {1'b0, addend};
    if (cfg_signed) begin
      upd_ovf = (p_ext[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != p_ext[ACC_WIDTH-1]);
    end else begin
      upd_ovf = sum[ACC_WIDTH];
    end
    acc_d = sum[ACC_WIDTH-1:0];
`ifdef DSP_MAC_SATURATE_EN
    if (upd_ovf) begin
      if (!cfg_signed) begin
        acc_d = '1;
      end else if (p_ext[ACC_WIDTH-1]) begin
        acc_d = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        acc_d = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end
`endif
    if (clr1_q || !cfg_sticky) begin
      ovf_d = upd_ovf;
    end else begin
      ovf_d = ovf_q | upd_ovf;
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      a_q    <= '0;
      b_q    <= '0;
      v0_q   <= 1'b0;
      clr0_q <= 1'b0;
      p_q    <= '0;
      v1_q   <= 1'b0;
      clr1_q <= 1'b0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      v2_q   <= 1'b0;
    end else if (bus.ce) begin
      a_q    <= bus.A;
      b_q    <= bus.B;
      v0_q   <= bus.in_valid;
      clr0_q <= bus.clr;
      p_q    <= prod;
      v1_q   <= v_eff;
      clr1_q <= clr_eff;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      v2_q   <= v1_q;
    end
  end

  assign bus.Q         = acc_q;
  assign bus.out_valid = v2_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_dsp_mac_bel.sv
// Directed self-checking bench for dsp_mac_bel (A=8, B=8, ACC=20), wrap or saturating build.
module tb_dsp_mac_bel;
  import dsp_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [4:0] cfg = '0;
  int         n_checks = 0;
  int         n_errors = 0;

  dsp_mac_bel_if #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(20)) bus ();

  dsp_mac_bel #(
    .A_WIDTH      (8),
    .B_WIDTH      (8),
    .ACC_WIDTH    (20),
    .NoConfigBits (5)
  ) dut (
    .UserCLK    (clk),
    .resetn     (resetn),
    .ConfigBits (cfg),
    .bus        (bus)
  );

  always #5 clk = ~clk;

`ifdef DSP_MAC_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic clr,
                       input logic vld);
    bus.A        = a;
    bus.B        = b;
    bus.clr      = clr;
    bus.in_valid = vld;
  endtask

  task automatic do_reset();
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    bus.C  = '0;
    bus.ce = 1'b1;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // 255*255 streamed in unsigned ACC mode; 17th product overflows 20 bits.
  task automatic run_u_ovf(input bit sticky);
    cfg = 5'b01000 | (sticky ? 5'b10000 : 5'b00000);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i < 18) drive(8'hFF, 8'hFF, i == 0, 1'b1);
      else        drive(8'h00, 8'h00, 1'b0, 1'b0);
      tick();
      if (i == 16) begin
        check("u_ovf_q16", bus.Q, 32'hFE010);
        check("u_ovf_f16", bus.ovf, 0);
      end else if (i == 17) begin
        check("u_ovf_q17", bus.Q, Sat ? 32'hFFFFF : 32'h0DE11);
        check("u_ovf_f17", bus.ovf, 1);
      end else if (i == 18) begin
        check("u_ovf_q18", bus.Q, Sat ? 32'hFFFFF : 32'h1DC12);
        check("u_ovf_f18", bus.ovf, (sticky || Sat) ? 1 : 0);
      end else if (i == 19) begin
        check("u_ovf_f19", bus.ovf, sticky ? 1 : 0);
      end
    end
    // clr reload drops the sticky flag
    drive(8'd1, 8'd1, 1'b1, 1'b1);
    tick();
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    check("u_ovf_clr_q", bus.Q, 1);
    check("u_ovf_clr_f", bus.ovf, 0);
  endtask

  initial begin
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    bus.C  = '0;
    bus.ce = 1'b1;
    #1;
    check("rst_q", bus.Q, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_vld", bus.out_valid, 0);

    // Asynchronous reset with a loaded accumulator (unsigned ADD, no regs)
    cfg = 5'b00000;
    do_reset();
    tick();
    bus.C = 20'h12345;
    drive(8'd0, 8'd0, 1'b0, 1'b1);
    tick();
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    check("load_q", bus.Q, 32'h12345);
    check("load_vld", bus.out_valid, 1);
    #2 resetn = 1'b0;
    #1;
    check("arst_q", bus.Q, 0);
    check("arst_ovf", bus.ovf, 0);
    check("arst_vld", bus.out_valid, 0);
    bus.C = '0;

    // Unsigned ACC, bypassed operands: 200, 212, 224, 236
    cfg = 5'b01000;
    do_reset();
    drive(8'd10, 8'd20, 1'b1, 1'b1);
    tick();
    check("acc_lat1_vld", bus.out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(8'd3, 8'd4, 1'b0, 1'b1);
      else       drive(8'd0, 8'd0, 1'b0, 1'b0);
      tick();
      check("acc_seq_q", bus.Q, 200 + 12 * i);
      check("acc_seq_vld", bus.out_valid, 1);
    end

    // Signed ADD, AREG only: -3*7+100 after exactly 3 edges
    cfg = 5'b00011;
    do_reset();
    bus.C = 20'd100;
    drive(8'hFD, 8'd7, 1'b0, 1'b1);
    tick();
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    check("sadd_e2_vld", bus.out_valid, 0);
    tick();
    check("sadd_q", bus.Q, 79);
    check("sadd_vld", bus.out_valid, 1);
    tick();
    check("sadd_next_q", bus.Q, 100);
    check("sadd_next_vld", bus.out_valid, 0);
    bus.C = '0;

    // ce gating mid-ACC: 4 + 9 + 25 with a 4-cycle stall between products
    cfg = 5'b01000;
    do_reset();
    drive(8'd2, 8'd2, 1'b1, 1'b1);
    tick();
    drive(8'd3, 8'd3, 1'b0, 1'b1);
    tick();
    check("ce_pre_q", bus.Q, 4);
    bus.ce = 1'b0;
    drive(8'd7, 8'd7, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ce_hold_q", bus.Q, 4);
      check("ce_hold_vld", bus.out_valid, 1);
    end
    bus.ce = 1'b1;
    drive(8'd5, 8'd5, 1'b0, 1'b1);
    tick();
    check("ce_res1_q", bus.Q, 13);
    drive(8'd0, 8'd0, 1'b0, 1'b0);
    tick();
    check("ce_res2_q", bus.Q, 38);
    check("ce_res2_vld", bus.out_valid, 1);
    tick();
    check("ce_res3_q", bus.Q, 38);
    check("ce_res3_vld", bus.out_valid, 0);

    run_u_ovf(1'b0);
    run_u_ovf(1'b1);

    // Signed ACC: (-128)*(-128) = 16384, 32nd product crosses 524287
    cfg = 5'b01001;
    do_reset();
    for (int i = 0; i < 34; i++) begin
      drive(8'h80, 8'h80, i == 0, 1'b1);
      tick();
      if (i == 31) begin
        check("s_ovf_q31", bus.Q, 32'h7C000);
        check("s_ovf_f31", bus.ovf, 0);
      end else if (i == 32) begin
        check("s_ovf_q32", bus.Q, Sat ? 32'h7FFFF : 32'h80000);
        check("s_ovf_f32", bus.ovf, 1);
      end else if (i == 33) begin
        check("s_ovf_q33", bus.Q, Sat ? 32'h7FFFF : 32'h84000);
        check("s_ovf_f33", bus.ovf, Sat ? 1 : 0);
      end
    end

    check("latency_fn", pipe_latency(cfg[CFG_AREG], cfg[CFG_BREG]), 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
